// File: rtl/user_gpio_irq_if.sv
// OBI subordinate port bundle for the user-domain GPIO interrupt block.
// The master drives the request phase; the slave returns gnt and a registered response.
interface user_gpio_irq_if #(
  parameter int IdWidth = 4
);
  logic               req;
  logic               gnt;
  logic [31:0]        addr;
  logic               we;
  logic [3:0]         be;
  logic [31:0]        wdata;
  logic [IdWidth-1:0] aid;
  logic               rvalid;
  logic [31:0]        rdata;
  logic [IdWidth-1:0] rid;
  logic               err;

  modport master (
    output req, addr, we, be, wdata, aid,
    input  gnt, rvalid, rdata, rid, err
  );

  modport slave (
    input  req, addr, we, be, wdata, aid,
    output gnt, rvalid, rdata, rid, err
  );
endinterface

// File: rtl/user_gpio_irq.sv
// GPIO edge-interrupt controller on OBI: optional glitch filter, sticky W1C pending, level irq.
// gnt = req (no backpressure); response one cycle after grant; level filter 1 cycle or N+1-tick stable.
module user_gpio_irq #(
  parameter int GpioCount = 16,
  parameter int IdWidth   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  user_gpio_irq_if.slave       obi,
  input  logic [GpioCount-1:0] gpio_in_i,
  output logic                 irq_o
);
  typedef logic [GpioCount-1:0] pins_t;

  localparam logic [2:0] OffRise  = 3'd0;
  localparam logic [2:0] OffFall  = 3'd1;
  localparam logic [2:0] OffPend  = 3'd2;
  localparam logic [2:0] OffIrqEn = 3'd3;
  localparam logic [2:0] OffDiv   = 3'd4;
  localparam logic [2:0] OffLevel = 3'd5;

  pins_t              rise_en_q, fall_en_q, pend_q, irq_en_q;
  pins_t              level_q, level_d1_q, samp_q;
  logic [15:0]        div_q, presc_q;
  logic               rvalid_q, err_q;
  logic [31:0]        rdata_q;
  logic [IdWidth-1:0] rid_q;

  logic [2:0]  off;
  logic        wr, rd, tick, div_wr;
  logic [31:0] bmask, rd_val;
  pins_t       pmask, wpins, w1c, rise, fall, stable;

  function automatic pins_t merge(pins_t old, pins_t val, pins_t m);
    return (old & ~m) | (val & m);
  endfunction

  always_comb begin
    off    = obi.addr[4:2];
    wr     = obi.req & obi.we;
    rd     = obi.req & ~obi.we;
    div_wr = wr && (off == OffDiv);
    bmask  = {{8{obi.be[3]}}, {8{obi.be[2]}}, {8{obi.be[1]}}, {8{obi.be[0]}}};
    pmask  = bmask[GpioCount-1:0];
    wpins  = obi.wdata[GpioCount-1:0];
    w1c    = (wr && off == OffPend) ? (wpins & pmask) : '0;
    rise   = level_q & ~level_d1_q & rise_en_q;
    fall   = ~level_q & level_d1_q & fall_en_q;
    tick   = (div_q != 16'd0) && (presc_q == div_q);
    // A pin is stable when the current input matches the value sampled on the previous tick.
    stable = ~(gpio_in_i ^ samp_q);
    rd_val = '0;
    case (off)
      OffRise:  rd_val[GpioCount-1:0] = rise_en_q;
      OffFall:  rd_val[GpioCount-1:0] = fall_en_q;
      OffPend:  rd_val[GpioCount-1:0] = pend_q;
      OffIrqEn: rd_val[GpioCount-1:0] = irq_en_q;
      OffDiv:   rd_val[15:0]          = div_q;
      OffLevel: rd_val[GpioCount-1:0] = level_q;
      default:  rd_val                = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      pend_q     <= '0;
      irq_en_q   <= '0;
      level_q    <= '0;
      level_d1_q <= '0;
      samp_q     <= '0;
      div_q      <= '0;
      presc_q    <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      rid_q      <= '0;
    end else begin
      rvalid_q <= obi.req;
      rid_q    <= obi.req ? obi.aid : '0;
      err_q    <= obi.req & off[2] & off[1];
      rdata_q  <= rd ? rd_val : '0;

      if (wr) begin
        case (off)
          OffRise:  rise_en_q <= merge(rise_en_q, wpins, pmask);
          OffFall:  fall_en_q <= merge(fall_en_q, wpins, pmask);
          OffIrqEn: irq_en_q  <= merge(irq_en_q, wpins, pmask);
          OffDiv:   div_q     <= {obi.be[1] ? obi.wdata[15:8] : div_q[15:8],
                                  obi.be[0] ? obi.wdata[7:0]  : div_q[7:0]};
          default:  ;
        endcase
      end

      // New edges win over a same-cycle clear.
      pend_q     <= (pend_q & ~w1c) | rise | fall;
      level_d1_q <= level_q;

      if (div_wr || div_q == 16'd0 || tick) presc_q <= '0;
      else                                  presc_q <= presc_q + 16'd1;

      if (div_q == 16'd0) begin
        level_q <= gpio_in_i;
      end else if (tick) begin
        level_q <= (level_q & ~stable) | (samp_q & stable);
        samp_q  <= gpio_in_i;
      end
    end
  end

  assign obi.gnt    = obi.req;
  assign obi.rvalid = rvalid_q;
  assign obi.rdata  = rdata_q;
  assign obi.rid    = rid_q;
  assign obi.err    = err_q;
  assign irq_o      = |(pend_q & irq_en_q);

  logic unused_bits;
  assign unused_bits = ^{obi.addr[31:5], obi.addr[1:0], obi.wdata, bmask};
endmodule

// File: tb/tb_user_gpio_irq.sv
// Directed and randomized bench for user_gpio_irq against a cycle-level reference of the register rules.
module tb_user_gpio_irq;
  localparam int N = 16;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [N-1:0] gpio;
  logic         irq;

  user_gpio_irq_if #(.IdWidth(4)) bus();

  user_gpio_irq #(.GpioCount(N), .IdWidth(4)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .obi       (bus),
    .gpio_in_i (gpio),
    .irq_o     (irq)
  );

  always #5 clk_i = ~clk_i;

  int ncmp  = 0;
  int nfail = 0;

  logic [N-1:0] m_rise, m_fall, m_pend, m_ien, m_lvl, m_lvlq, m_samp;
  logic [15:0]  m_div;
  int           m_cnt = 0;
  logic         m_rvalid, m_err;
  logic [31:0]  m_rdata;
  logic [3:0]   m_rid;

  logic [31:0]  obs_rdata;
  logic         obs_err, obs_rvalid;
  logic [3:0]   obs_rid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next state of the register file from the inputs present during the coming edge.
  task automatic model_step();
    logic [N-1:0] lane, wv, rise, fall, n_lvl, n_samp, n_pend;
    logic [31:0]  lane32, val;
    int           off, n_cnt;
    if (rst_i) begin
      {m_rise, m_fall, m_pend, m_ien, m_lvl, m_lvlq, m_samp} = '0;
      m_div = '0; m_cnt = 0;
      m_rvalid = 1'b0; m_err = 1'b0; m_rdata = '0; m_rid = '0;
      return;
    end
    off = int'(bus.addr[4:2]);
    for (int b = 0; b < 4; b++) lane32[b*8 +: 8] = {8{bus.be[b]}};
    lane = lane32[N-1:0];
    wv   = bus.wdata[N-1:0];
    case (off)
      0: val = 32'(m_rise);
      1: val = 32'(m_fall);
      2: val = 32'(m_pend);
      3: val = 32'(m_ien);
      4: val = 32'(m_div);
      5: val = 32'(m_lvl);
      default: val = 32'd0;
    endcase
    m_rvalid = bus.req;
    m_rid    = bus.aid;
    m_err    = bus.req && off >= 6;
    m_rdata  = (bus.req && !bus.we) ? val : 32'd0;

    rise   = m_lvl & ~m_lvlq & m_rise;
    fall   = ~m_lvl & m_lvlq & m_fall;
    n_pend = m_pend;
    if (bus.req && bus.we && off == 2) n_pend = n_pend & ~(wv & lane);
    n_pend = n_pend | rise | fall;

    n_lvl = m_lvl; n_samp = m_samp; n_cnt = m_cnt;
    if (m_div == 0) begin
      n_lvl = gpio; n_cnt = 0;
    end else if (m_cnt == int'(m_div)) begin
      for (int i = 0; i < N; i++) if (gpio[i] == m_samp[i]) n_lvl[i] = m_samp[i];
      n_samp = gpio; n_cnt = 0;
    end else begin
      n_cnt = m_cnt + 1;
    end

    if (bus.req && bus.we) begin
      case (off)
        0: m_rise = (m_rise & ~lane) | (wv & lane);
        1: m_fall = (m_fall & ~lane) | (wv & lane);
        3: m_ien  = (m_ien & ~lane) | (wv & lane);
        4: begin
          m_div = (m_div & ~lane32[15:0]) | (bus.wdata[15:0] & lane32[15:0]);
          n_cnt = 0;
        end
        default: ;
      endcase
    end
    m_pend = n_pend;
    m_lvlq = m_lvl;
    m_lvl  = n_lvl;
    m_samp = n_samp;
    m_cnt  = n_cnt;
  endtask

  task automatic cycle();
    #2;
    chk("gnt", 32'(bus.gnt), 32'(bus.req));
    model_step();
    @(posedge clk_i);
    #1;
    obs_rvalid = bus.rvalid;
    obs_rdata  = bus.rdata;
    obs_rid    = bus.rid;
    obs_err    = bus.err;
    chk("rvalid", 32'(obs_rvalid), 32'(m_rvalid));
    chk("irq", 32'(irq), 32'(|(m_pend & m_ien)));
    if (m_rvalid) begin
      chk("rid", 32'(obs_rid), 32'(m_rid));
      chk("err", 32'(obs_err), 32'(m_err));
      chk("rdata", obs_rdata, m_rdata);
    end
  endtask

  task automatic bus_idle();
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.be = '0; bus.wdata = '0; bus.aid = '0;
  endtask

  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [3:0] aid);
    bus.req = 1'b1; bus.we = we; bus.addr = addr; bus.wdata = wdata; bus.be = be; bus.aid = aid;
    cycle();
    bus_idle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst_i = 1'b1;
    gpio  = '0;
    bus_idle();
    idle(2);
    rst_i = 1'b0;

    for (int o = 0; o < 6; o++) begin
      xfer(1'b0, 32'(o * 4), 32'd0, 4'hf, 4'd0);
      chk("rst_rdata", obs_rdata, 32'd0);
      chk("rst_err", 32'(obs_err), 32'd0);
    end
    chk("rst_irq", 32'(irq), 32'd0);

    // Bypass edge into pending and W1C.
    xfer(1'b1, 32'h00, 32'h1, 4'hf, 4'd0);
    xfer(1'b1, 32'h0C, 32'h1, 4'hf, 4'd0);
    gpio[0] = 1'b1;
    idle(2);
    xfer(1'b0, 32'h08, 32'd0, 4'hf, 4'd1);
    chk("edge_pend", obs_rdata, 32'h1);
    chk("edge_irq", 32'(irq), 32'd1);
    xfer(1'b1, 32'h08, 32'h1, 4'hf, 4'd0);
    chk("w1c_irq", 32'(irq), 32'd0);

    // Glitch filter with a divide of 3.
    xfer(1'b1, 32'h00, 32'h21, 4'hf, 4'd0);
    xfer(1'b1, 32'h10, 32'h3, 4'hf, 4'd0);
    gpio[5] = 1'b1;
    idle(2);
    gpio[5] = 1'b0;
    idle(10);
    xfer(1'b0, 32'h14, 32'd0, 4'hf, 4'd0);
    chk("filt_glitch_lvl", obs_rdata & 32'h20, 32'd0);
    xfer(1'b0, 32'h08, 32'd0, 4'hf, 4'd0);
    chk("filt_glitch_pend", obs_rdata, 32'd0);
    gpio[5] = 1'b1;
    idle(8);
    xfer(1'b0, 32'h14, 32'd0, 4'hf, 4'd0);
    chk("filt_stable_lvl", obs_rdata & 32'h20, 32'h20);
    xfer(1'b1, 32'h10, 32'h0, 4'hf, 4'd0);
    gpio[5] = 1'b0;
    idle(2);
    xfer(1'b1, 32'h08, 32'hFFFF, 4'hf, 4'd0);

    // Fall edge and clear landing on the same edge.
    xfer(1'b1, 32'h04, 32'h8000, 4'hf, 4'd0);
    gpio[15] = 1'b1;
    idle(3);
    gpio[15] = 1'b0;
    cycle();
    xfer(1'b1, 32'h08, 32'h8000, 4'hf, 4'd0);
    xfer(1'b0, 32'h08, 32'd0, 4'hf, 4'd0);
    chk("collide_pend", obs_rdata & 32'h8000, 32'h8000);

    // Back-to-back transactions, error window, byte enables.
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h00; bus.be = 4'hf; bus.aid = 4'h3;
    cycle();
    chk("b2b_rv1", 32'(obs_rvalid), 32'd1);
    chk("b2b_rid1", 32'(obs_rid), 32'h3);
    bus.we = 1'b1; bus.addr = 32'h04; bus.wdata = 32'h8000; bus.aid = 4'h5;
    cycle();
    chk("b2b_rv2", 32'(obs_rvalid), 32'd1);
    chk("b2b_rid2", 32'(obs_rid), 32'h5);
    bus_idle();
    cycle();
    chk("b2b_rv_idle", 32'(obs_rvalid), 32'd0);
    xfer(1'b0, 32'h18, 32'd0, 4'hf, 4'd2);
    chk("oob_err", 32'(obs_err), 32'd1);
    chk("oob_rdata", obs_rdata, 32'd0);
    xfer(1'b1, 32'h00, 32'hFFFF, 4'b0001, 4'd0);
    xfer(1'b0, 32'h00, 32'd0, 4'hf, 4'd0);
    chk("be_rise_en", obs_rdata, 32'h00FF);

    // Reset landing on a granted read.
    gpio[0] = 1'b0;
    idle(2);
    gpio[0] = 1'b1;
    idle(2);
    chk("pre_rst_irq", 32'(irq), 32'd1);
    rst_i = 1'b1;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h08; bus.be = 4'hf; bus.aid = 4'h7;
    cycle();
    bus_idle();
    rst_i = 1'b0;
    cycle();
    chk("midrst_rvalid", 32'(obs_rvalid), 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    xfer(1'b0, 32'h08, 32'd0, 4'hf, 4'd0);
    chk("midrst_pend", obs_rdata, 32'd0);
    xfer(1'b0, 32'h0C, 32'd0, 4'hf, 4'd0);
    chk("midrst_irq_en", obs_rdata, 32'd0);

    // Randomized traffic against the reference.
    for (int i = 0; i < 800; i++) begin
      rst_i     = ($urandom_range(0, 199) == 0);
      bus.req   = 1'($urandom_range(0, 1));
      bus.we    = 1'($urandom_range(0, 1));
      bus.addr  = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      bus.be    = 4'($urandom);
      bus.wdata = $urandom;
      if (bus.addr[4:2] == 3'd4) bus.wdata = 32'($urandom_range(0, 4));
      bus.aid   = 4'($urandom);
      gpio      = gpio ^ N'($urandom & $urandom & $urandom);
      cycle();
    end
    rst_i = 1'b0;
    bus_idle();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
